// File: rtl/simon_seq_engine.sv
// simon_seq_engine: parametrised Simon game core.
//   Generates a pseudo-random colour sequence with an LFSR, plays it back with
//   a per-level speed-up, checks the player's replay against a timeout, and
//   reports game over, win and the reached level.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   start         in   begin a new game (honoured in idle/over/win)
//   btn_num       in   [CH_W-1:0] index of the pressed button
//   btn_pressed   in   high while any button is held
//   simon_turn    out  engine owns LEDs/tone
//   simon_num     out  [CH_W-1:0] channel being played back
//   simon_pressed out  playback on-phase
//   game_over     out  high in over
//   win           out  high in win
//   level         out  [LEN_W-1:0] current sequence length / score
//
// state       | meaning
// ------------+---------------------------------------------------
// st_idle     | waiting for start, all outputs low
// st_add      | append one random step, level+1 (one cycle)
// st_show_on  | playing step idx, light/tone on for on_len ticks
// st_show_off | gap after a step, OFF_TICKS ticks
// st_wait_in  | player replays the sequence, timeout armed
// st_pause    | round complete, wait for release then OFF_TICKS
// st_over     | wrong press or timeout, level frozen
// st_win      | MAX_LEN reached
module simon_seq_engine #(
  parameter int          N_CH          = 4,
  parameter int          CH_W          = 2,
  parameter int          MAX_LEN       = 16,
  parameter int          LEN_W         = 5,
  parameter int          TICK_DIV      = 25000000,
  parameter int          ON_TICKS      = 6,
  parameter int          OFF_TICKS     = 2,
  parameter int          SPEEDUP       = 1,
  parameter int          MIN_ON_TICKS  = 2,
  parameter int          TIMEOUT_TICKS = 20,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CH_W-1:0]  btn_num,
  input  logic             btn_pressed,
  output logic             simon_turn,
  output logic [CH_W-1:0]  simon_num,
  output logic             simon_pressed,
  output logic             game_over,
  output logic             win,
  output logic [LEN_W-1:0] level
);

  localparam int TMAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TMAX_B = (TIMEOUT_TICKS > MIN_ON_TICKS) ? TIMEOUT_TICKS : MIN_ON_TICKS;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TK_W   = $clog2(TMAX + 1);
  localparam int PS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LOAD = PS_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    st_idle, st_add, st_show_on, st_show_off,
    st_wait_in, st_pause, st_over, st_win
  } state_t;

  state_t            st, st_nxt;
  logic [15:0]       lfsr;
  logic              btn_q;
  logic [LEN_W-1:0]  idx, idx_nxt, level_nxt;
  logic [CH_W-1:0]   mem [MAX_LEN];
  logic [PS_W-1:0]   presc;
  logic [TK_W-1:0]   tick_cnt;
  logic [TK_W-1:0]   on_last;
  logic              tick, press, tmr_restart, tmr_clr, mem_we;
  logic              on_done, off_done, to_done;
  logic [CH_W-1:0]   step_val, cur_val, rd_val;
  int                on_len_i;

  // Fibonacci LFSR, taps 16,14,13,11 in shift-right form.
  logic lfsr_fb;
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_comb begin
    step_val = lfsr[CH_W-1:0];
    if ({1'b0, lfsr[CH_W-1:0]} >= (CH_W+1)'(N_CH))
      step_val = lfsr[CH_W-1:0] - CH_W'(N_CH);
  end

  // Saturating on-time: never drops below MIN_ON_TICKS, no underflow.
  always_comb begin
    on_len_i = ON_TICKS;
    if (level > LEN_W'(1)) begin
      if ((int'(level) - 1) * SPEEDUP >= ON_TICKS - MIN_ON_TICKS)
        on_len_i = MIN_ON_TICKS;
      else
        on_len_i = ON_TICKS - (int'(level) - 1) * SPEEDUP;
    end
    if (on_len_i < MIN_ON_TICKS)
      on_len_i = MIN_ON_TICKS;
  end

  assign on_last  = TK_W'(on_len_i - 1);
  assign tick     = (presc == '0);
  assign on_done  = tick && (tick_cnt == on_last);
  assign off_done = tick && (tick_cnt == TK_W'(OFF_TICKS - 1));
  assign to_done  = tick && (tick_cnt == TK_W'(TIMEOUT_TICKS - 1));
  assign press    = btn_pressed & ~btn_q;

  always_comb begin
    cur_val = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (idx == LEN_W'(i)) cur_val = mem[i];
  end

  always_comb begin
    st_nxt      = st;
    idx_nxt     = idx;
    level_nxt   = level;
    mem_we      = 1'b0;
    tmr_restart = 1'b0;
    case (st)
      st_idle, st_over, st_win: begin
        if (start) begin
          st_nxt    = st_add;
          level_nxt = '0;
        end
      end
      st_add: begin
        mem_we    = 1'b1;
        level_nxt = level + 1'b1;
        idx_nxt   = '0;
        st_nxt    = st_show_on;
      end
      st_show_on: begin
        if (on_done) st_nxt = st_show_off;
      end
      st_show_off: begin
        if (off_done) begin
          if (idx == level - 1'b1) begin
            idx_nxt = '0;
            st_nxt  = st_wait_in;
          end else begin
            idx_nxt = idx + 1'b1;
            st_nxt  = st_show_on;
          end
        end
      end
      st_wait_in: begin
        // A press in the same cycle as timeout expiry takes priority.
        if (press) begin
          if (btn_num == cur_val) begin
            if (idx == level - 1'b1) begin
              st_nxt = (level == LEN_W'(MAX_LEN)) ? st_win : st_pause;
            end else begin
              idx_nxt     = idx + 1'b1;
              tmr_restart = 1'b1;
            end
          end else begin
            st_nxt = st_over;
          end
        end else if (to_done) begin
          st_nxt = st_over;
        end
      end
      st_pause: begin
        // The gap only starts counting once every button is released.
        if (btn_pressed) tmr_restart = 1'b1;
        else if (off_done) st_nxt = st_add;
      end
      default: st_nxt = st_idle;
    endcase
  end

  assign tmr_clr = tmr_restart | (st_nxt != st);

  // Playback channel for the next cycle; bypass covers writing and showing
  // the same slot on the add -> show_on edge.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (idx_nxt == LEN_W'(i)) rd_val = mem[i];
    if (mem_we && (idx_nxt == level))
      rd_val = step_val;
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int i = 0; i < MAX_LEN; i++)
        if (level == LEN_W'(i)) mem[i] <= step_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st            <= st_idle;
      lfsr          <= SEED;
      btn_q         <= 1'b0;
      idx           <= '0;
      level         <= '0;
      presc         <= PS_LOAD;
      tick_cnt      <= '0;
      simon_turn    <= 1'b0;
      simon_num     <= '0;
      simon_pressed <= 1'b0;
      game_over     <= 1'b0;
      win           <= 1'b0;
    end else begin
      st    <= st_nxt;
      lfsr  <= {lfsr_fb, lfsr[15:1]};
      btn_q <= btn_pressed;
      idx   <= idx_nxt;
      level <= level_nxt;
      if (tmr_clr || tick) presc <= PS_LOAD;
      else                 presc <= presc - 1'b1;
      if (tmr_clr)   tick_cnt <= '0;
      else if (tick) tick_cnt <= tick_cnt + 1'b1;
      simon_turn    <= (st_nxt == st_add) || (st_nxt == st_show_on) ||
                       (st_nxt == st_show_off) || (st_nxt == st_pause);
      simon_pressed <= (st_nxt == st_show_on);
      simon_num     <= ((st_nxt == st_show_on) || (st_nxt == st_show_off)) ? rd_val : '0;
      game_over     <= (st_nxt == st_over);
      win           <= (st_nxt == st_win);
    end
  end

endmodule

// File: tb/tb_simon_seq_engine.sv
module tb_simon_seq_engine;
  localparam int N_CH     = 4;
  localparam int CH_W     = 2;
  localparam int MAX_LEN  = 3;
  localparam int LEN_W    = 5;
  localparam int TICK_DIV = 2;
  localparam int ON_T     = 3;
  localparam int OFF_T    = 1;
  localparam int SPD      = 1;
  localparam int MIN_ON   = 1;
  localparam int TO_T     = 8;

  localparam int EV_SHOW = 0;
  localparam int EV_OVER = 1;
  localparam int EV_WIN  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic btn_pressed = 1'b0;
  logic [CH_W-1:0] btn_num = '0;
  logic simon_turn, simon_pressed, game_over, win;
  logic [CH_W-1:0] simon_num;
  logic [LEN_W-1:0] level;

  always #5 clk = ~clk;

  simon_seq_engine #(
    .N_CH(N_CH), .CH_W(CH_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W),
    .TICK_DIV(TICK_DIV), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .SPEEDUP(SPD),
    .MIN_ON_TICKS(MIN_ON), .TIMEOUT_TICKS(TO_T), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .btn_num(btn_num),
    .btn_pressed(btn_pressed), .simon_turn(simon_turn), .simon_num(simon_num),
    .simon_pressed(simon_pressed), .game_over(game_over), .win(win),
    .level(level)
  );

  typedef struct {
    int kind;
    int num;
    int width;
  } ev_t;

  ev_t exp_q[$];
  int  seq[$];
  int  total = 0;
  int  bad = 0;
  logic [15:0] m_lfsr;

  // Reference LFSR: classic 16-bit Fibonacci, x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic [15:0] b;
    b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'h0001;
    return (l >> 1) | (b << 15);
  endfunction

  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic int chan_of(input logic [15:0] l);
    int v;
    v = int'(l) % (1 << CH_W);
    if (v >= N_CH) v = v - N_CH;
    return v;
  endfunction

  function automatic int on_cycles(input int lvl);
    int on;
    on = ON_T - (lvl - 1) * SPD;
    if (on < MIN_ON) on = MIN_ON;
    return on * TICK_DIV;
  endfunction

  function automatic int show_cycles(input int lvl);
    return 1 + lvl * (on_cycles(lvl) + OFF_T * TICK_DIV);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_check(input int kind, input int num, input int width);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d num %0d expected none", kind, num);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_num", num, e.num);
      if (kind == EV_SHOW) chk("ev_width", width, e.width);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called during the add cycle: the step comes from the current LFSR value.
  task automatic add_round();
    int lvl;
    seq.push_back(chan_of(m_lfsr));
    lvl = seq.size();
    for (int i = 0; i < lvl; i++)
      exp_q.push_back('{EV_SHOW, seq[i], on_cycles(lvl)});
  endtask

  task automatic start_game();
    start = 1'b1;
    cyc();
    start = 1'b0;
    seq.delete();
    add_round();
    chk("add_turn", simon_turn, 1);
  endtask

  // Runs from the current cycle until the first wait_in cycle; stray start
  // pulses during playback must be ignored.
  task automatic wait_show(input int skip);
    int n;
    n = show_cycles(seq.size()) - skip;
    for (int i = 0; i < n; i++) begin
      start = ($urandom_range(0, 7) == 0);
      cyc();
    end
    start = 1'b0;
  endtask

  task automatic press(input int num, input int hold);
    logic [31:0] nv;
    nv = num;
    btn_num = nv[CH_W-1:0];
    btn_pressed = 1'b1;
    repeat (hold) cyc();
    btn_pressed = 1'b0;
  endtask

  task automatic replay_level();
    int lvl;
    int gap;
    lvl = seq.size();
    for (int i = 0; i < lvl; i++) begin
      if (i == lvl - 1 && lvl == MAX_LEN)
        exp_q.push_back('{EV_WIN, MAX_LEN, 0});
      press(seq[i], $urandom_range(1, 3));
      if (i < lvl - 1) begin
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) begin
          start = ($urandom_range(0, 3) == 0);
          cyc();
        end
        start = 1'b0;
      end
    end
    if (lvl == MAX_LEN) begin
      chk("win_flag", win, 1);
      chk("win_level", int'(level), MAX_LEN);
      chk("win_turn", simon_turn, 0);
    end else begin
      repeat (2) cyc();
      add_round();
    end
  endtask

  int  m_w = 0;
  int  m_num = 0;
  bit  m_in = 0;
  bit  m_go = 0;
  bit  m_win = 0;
  int  wrong;

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (reset) begin
          m_in = 0; m_w = 0; m_go = 0; m_win = 0;
        end else begin
          if (simon_pressed) begin
            if (!m_in) begin
              m_in = 1;
              m_w = 0;
              m_num = int'(simon_num);
            end
            m_w++;
          end else if (m_in) begin
            m_in = 0;
            pop_check(EV_SHOW, m_num, m_w);
          end
          if (game_over && !m_go) pop_check(EV_OVER, int'(level), 0);
          if (win && !m_win) pop_check(EV_WIN, int'(level), 0);
          m_go = game_over;
          m_win = win;
        end
      end
    join_none

    // Reset and idle.
    reset = 1'b1;
    cyc();
    chk("rst_turn", simon_turn, 0);
    chk("rst_pressed", simon_pressed, 0);
    chk("rst_num", int'(simon_num), 0);
    chk("rst_over", game_over, 0);
    chk("rst_win", win, 0);
    chk("rst_level", int'(level), 0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("idle_turn", simon_turn, 0);

    // Game 1: full correct replay to win.
    start_game();
    cyc();
    chk("g1_level", int'(level), 1);
    chk("g1_turn", simon_turn, 1);
    chk("g1_pressed", simon_pressed, 1);
    wait_show(1);
    replay_level();
    wait_show(0);
    replay_level();
    wait_show(0);
    replay_level();

    // Game 2: wrong first press at level 2.
    start_game();
    wait_show(0);
    replay_level();
    wait_show(0);
    wrong = (seq[0] + int'($urandom_range(1, N_CH - 1))) % N_CH;
    exp_q.push_back('{EV_OVER, 2, 0});
    press(wrong, 1);
    chk("g2_over", game_over, 1);
    chk("g2_level", int'(level), 2);
    cyc();

    // Game 3: timeout at level 1.
    start_game();
    cyc();
    chk("g3_level", int'(level), 1);
    wait_show(1);
    exp_q.push_back('{EV_OVER, 1, 0});
    repeat (2 * TO_T - 1) cyc();
    chk("g3_before_to", game_over, 0);
    cyc();
    chk("g3_timeout", game_over, 1);
    chk("g3_to_level", int'(level), 1);

    // Game 4: wrong button held across show_off -> wait_in is not a press.
    start_game();
    repeat (show_cycles(1) - 1) cyc();
    btn_num = CH_W'((seq[0] + 1) % N_CH);
    btn_pressed = 1'b1;
    repeat (4) cyc();
    btn_pressed = 1'b0;
    cyc();
    chk("g4_held_over", game_over, 0);
    chk("g4_held_turn", simon_turn, 0);
    replay_level();
    chk("g4_level", int'(level), 1);
    repeat (3) cyc();
    chk("g4_show_on", simon_pressed, 1);
    reset = 1'b1;
    exp_q.delete();
    cyc();
    chk("g4_rst_pressed", simon_pressed, 0);
    chk("g4_rst_turn", simon_turn, 0);
    chk("g4_rst_level", int'(level), 0);
    chk("g4_rst_num", int'(simon_num), 0);
    reset = 1'b0;
    cyc();

    // Game 5: start accepted again from idle, played to win.
    start_game();
    cyc();
    chk("g5_level", int'(level), 1);
    chk("g5_pressed", simon_pressed, 1);
    wait_show(1);
    replay_level();
    wait_show(0);
    replay_level();
    wait_show(0);
    replay_level();
    repeat (4) cyc();
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
